time_counter: RTL and testbench
===============================

# time_counter

Timekeeping core of the alarm clock: divides the system clock down to a 1 Hz enable and keeps 24-hour time as six BCD digits (HH:MM:SS). It sits directly upstream of the seven-segment decoders, and each BCD output drives one `seg7` instance unchanged. It also accepts single-cycle set pulses from the button debouncer and produces a per-second tick and a half-second blink phase for the colon and the alarm logic.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second. It must be ≥ 2; the prescaler width is `$clog2(CLK_HZ)`.

Ports:
- `clk`: in, 1. System clock.
- `reset`: in, 1. One clock; reset is asynchronous and active-high.
- `run`: in, 1. Level. When high, the prescaler advances; when low, time freezes.
- `set_hr`: in, 1. Single-cycle pulse. Increments hours mod 24.
- `set_min`: in, 1. Single-cycle pulse. Increments minutes mod 60, with no carry into hours.
- `clr_sec`: in, 1. Single-cycle pulse. Zeroes the seconds and the prescaler.
- `hr_tens`: out, 4. BCD, range 0–2.
- `hr_ones`: out, 4. BCD, range 0–9 (0–3 when `hr_tens` is 2).
- `min_tens`, `sec_tens`: out, 4 each. BCD, range 0–5.
- `min_ones`, `sec_ones`: out, 4 each. BCD, range 0–9.
- `tick`: out, 1. One-cycle pulse on each one-second rollover.
- `sec_half`: out, 1. High while the prescaler is below `CLK_HZ/2`; used for colon blink.

## Operation
- **Reset:** all digits go to 0 (00:00:00), the prescaler to 0, `tick` to 0. `sec_half` is 1 because it decodes from prescaler = 0.
- **Prescaler:** counts 0..`CLK_HZ-1` while `run` is high, then wraps to 0. The wrap cycle is the terminal event `sec_en`.
- **Seconds:**
  - On `sec_en`, `sec_ones` increments.
  - 9 → 0 carries into `sec_tens`.
  - 59 → 00 raises the minute carry `min_cy`.
- **Minutes:** increment when `min_cy` or `set_min` is asserted. If both arrive in the same cycle, minutes increment by exactly one.
  - 59 → 00 raises the hour carry `hr_cy`, but only when the increment came from `min_cy`. A `set_min` wrap never advances hours.
- **Hours:** increment when `hr_cy` or `set_hr` is asserted; if both, by exactly one.
  - Wrap is 23 → 00.
  - 09 → 10 and 19 → 20 are ordinary BCD carries.
- **`clr_sec` priority:** `clr_sec` beats `sec_en` in the same cycle. Seconds become 00, the prescaler becomes 0, `tick` stays low, and no minute carry is generated. Minutes and hours still honour `set_min` and `set_hr` in that cycle.
- **`run` low:** freezes the prescaler; `tick` is never asserted while frozen. `set_hr`, `set_min` and `clr_sec` still act while `run` is low.
- **Illegal values:** digit values outside their range are unreachable. There are no load ports, so no illegal-state recovery is needed beyond reset.
- **Reset mid-operation:** returns immediately (asynchronously) to 00:00:00. Any pending set pulse is lost.

## Timing
- All digit registers and `tick` update on the rising `clk` edge that follows the cycle in which the prescaler equals `CLK_HZ-1` with `run` high. `tick` is high for exactly that one following cycle.
- The entire ripple 23:59:59 → 00:00:00 completes in that same single edge. The carry chain is combinational between digit registers, so no digit lags.
- Set pulse → digit change: 1 cycle.
- `sec_half` is combinational from the prescaler register: high for `CLK_HZ/2` cycles (rounded down), then low for the remainder.
- Tick period is exactly `CLK_HZ` cycles while `run` stays high.

## Structure
- Shared package `clock_pkg`: digit limit constants `SEC_TENS_MAX=5`, `MIN_TENS_MAX=5`, `HR_WRAP_TENS=2`, `HR_WRAP_ONES=3`, and a `bcd_t` 4-bit typedef reused by `seg7` instances and the alarm comparator.
- Sub-module `bcd_digit`:
  - Parameter `MAX`.
  - Inputs `clk`, `reset`, `inc`, `clr`.
  - Outputs `q` (4-bit BCD) and `wrap`, where `wrap` is combinational: `inc` is high and `q` equals `MAX`.
- Seconds and minutes use two `bcd_digit` instances each. Hours use two instances plus top-level logic that forces both to clear at 23.
- The prescaler and the priority logic live in `time_counter`.

## Test plan
All scenarios use a bench with `CLK_HZ=4`.
1. Reset, then `run`=1 for 40 cycles → 00:00:10; `tick` pulses exactly 10 times, spaced 4 cycles apart; `sec_half` is high 2 cycles and low 2 cycles.
2. Preset to 23:59:58 via set pulses plus running, then 8 cycles → 00:00:00. All six digits change on the same edge and `tick` is high on that cycle.
3. At minutes = 59, pulse `set_min` → minutes 00, hours unchanged. Pulse `set_hr` 24 times from 00 → 00, passing 09 → 10 and 19 → 20.
4. Assert `clr_sec` in the cycle where the prescaler = 3 and seconds = 59 → seconds 00, no `tick`, minutes unchanged, prescaler 0.
5. `run`=0 with time 12:34:56 held for 20 cycles → no `tick` and digits stable. `set_min` during the hold → 12:35:56.
6. Assert `reset` asynchronously mid-cycle at 07:07:07 → outputs read 00:00:00 before the next `clk` edge; counting resumes from 0 after `reset` deasserts.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock definitions: the BCD digit type and the per-digit limits used by
// the time counter, the seg7 decoders and the alarm comparator.
package clock_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t ONES_MAX     = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t MIN_TENS_MAX = 4'd5;
   localparam bcd_t HR_WRAP_TENS = 4'd2;
   localparam bcd_t HR_WRAP_ONES = 4'd3;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX with a synchronous clear and a combinational
// wrap output that feeds the next digit's increment in the same cycle.
module bcd_digit
   import clock_pkg::*;
#(
   parameter bcd_t MAX = 4'd9
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output bcd_t q,
   output logic wrap
);

   assign wrap = inc && (q == MAX);

   // Clear wins over increment so a forced 23->00 or clr_sec overrides any carry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == MAX) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/time_counter.sv
// 24-hour HH:MM:SS timekeeper: prescales clk to a 1 Hz enable and ripples the
// carry through six BCD digits in a single edge; also takes manual set pulses.
module time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic set_hr,
   input  logic set_min,
   input  logic clr_sec,
   output bcd_t hr_tens,
   output bcd_t hr_ones,
   output bcd_t min_tens,
   output bcd_t min_ones,
   output bcd_t sec_tens,
   output bcd_t sec_ones,
   output logic tick,
   output logic sec_half
);

   localparam int W = $clog2(CLK_HZ);
   localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
   localparam logic [W-1:0] HALF = W'(CLK_HZ / 2);

   logic [W-1:0] presc;
   logic sec_en;
   logic sec_inc;
   logic so_wrap, st_wrap, mo_wrap, mt_wrap, ho_wrap, ht_wrap;
   logic min_cy, min_inc, hr_cy, hr_inc, hr_clr;

   assign sec_en   = run && (presc == LAST);
   assign sec_half = presc < HALF;

   // clr_sec restarts the second, so it also zeroes the prescaler.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= sec_en && !clr_sec;
         if (clr_sec) begin
            presc <= '0;
         end else if (run) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
         end
      end
   end

   assign sec_inc = sec_en && !clr_sec;
   assign min_cy  = st_wrap;
   assign min_inc = min_cy || set_min;
   // A minute wrap caused purely by set_min must not advance the hours.
   assign hr_cy   = mt_wrap && min_cy;
   assign hr_inc  = hr_cy || set_hr;
   assign hr_clr  = hr_inc && (hr_tens == HR_WRAP_TENS) && (hr_ones == HR_WRAP_ONES);

   bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
      .clk(clk), .reset(reset), .inc(sec_inc), .clr(clr_sec), .q(sec_ones), .wrap(so_wrap)
   );
   bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .reset(reset), .inc(so_wrap), .clr(clr_sec), .q(sec_tens), .wrap(st_wrap)
   );
   bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
      .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0), .q(min_ones), .wrap(mo_wrap)
   );
   bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(clk), .reset(reset), .inc(mo_wrap), .clr(1'b0), .q(min_tens), .wrap(mt_wrap)
   );
   bcd_digit #(.MAX(ONES_MAX)) u_hr_ones (
      .clk(clk), .reset(reset), .inc(hr_inc), .clr(hr_clr), .q(hr_ones), .wrap(ho_wrap)
   );
   bcd_digit #(.MAX(HR_WRAP_TENS)) u_hr_tens (
      .clk(clk), .reset(reset), .inc(ho_wrap), .clr(hr_clr), .q(hr_tens), .wrap(ht_wrap)
   );

   logic unused;
   assign unused = ht_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Directed plus randomized bench for time_counter at CLK_HZ=4, checked against a
// time-of-day model kept as plain hour/minute/second integers.
module tb_time_counter;

   localparam int HZ = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b0;
   logic set_hr = 1'b0;
   logic set_min = 1'b0;
   logic clr_sec = 1'b0;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic tick, sec_half;

   int assertion_count = 0;
   int fail_count = 0;

   int m_hh = 0, m_mm = 0, m_ss = 0, m_phase = 0;
   logic m_tick = 1'b0;
   int tick_count = 0;

   time_counter #(.CLK_HZ(HZ)) dut (
      .clk(clk), .reset(reset), .run(run), .set_hr(set_hr), .set_min(set_min),
      .clr_sec(clr_sec), .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
      .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones), .tick(tick),
      .sec_half(sec_half)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assertion_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_output();
      check_val("hr_tens", {4'd0, hr_tens}, 8'(m_hh / 10));
      check_val("hr_ones", {4'd0, hr_ones}, 8'(m_hh % 10));
      check_val("min_tens", {4'd0, min_tens}, 8'(m_mm / 10));
      check_val("min_ones", {4'd0, min_ones}, 8'(m_mm % 10));
      check_val("sec_tens", {4'd0, sec_tens}, 8'(m_ss / 10));
      check_val("sec_ones", {4'd0, sec_ones}, 8'(m_ss % 10));
      check_val("tick", {7'd0, tick}, {7'd0, m_tick});
      check_val("sec_half", {7'd0, sec_half}, {7'd0, (m_phase < HZ / 2)});
   endtask

   // Reference: time of day as integers, advanced by the rules in plain arithmetic.
   task automatic model_step(input logic r, input logic sh, input logic sm, input logic cs);
      logic min_carry;
      logic hr_carry;
      min_carry = 1'b0;
      hr_carry = 1'b0;
      m_tick = 1'b0;
      if (cs) begin
         m_ss = 0;
         m_phase = 0;
      end else if (r) begin
         if (m_phase == HZ - 1) begin
            m_phase = 0;
            m_tick = 1'b1;
            m_ss = m_ss + 1;
            if (m_ss == 60) begin
               m_ss = 0;
               min_carry = 1'b1;
            end
         end else begin
            m_phase = m_phase + 1;
         end
      end
      if (min_carry || sm) begin
         m_mm = (m_mm + 1) % 60;
         if (m_mm == 0 && min_carry) hr_carry = 1'b1;
      end
      if (hr_carry || sh) m_hh = (m_hh + 1) % 24;
   endtask

   task automatic apply_stimulus(input logic r, input logic sh, input logic sm, input logic cs);
      run = r;
      set_hr = sh;
      set_min = sm;
      clr_sec = cs;
      @(posedge clk);
      model_step(r, sh, sm, cs);
      #1;
      set_hr = 1'b0;
      set_min = 1'b0;
      clr_sec = 1'b0;
      if (tick) tick_count++;
      check_output();
   endtask

   task automatic model_reset();
      m_hh = 0;
      m_mm = 0;
      m_ss = 0;
      m_phase = 0;
      m_tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_output();
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      logic r, sh, sm, cs;

      $display("[TB] reset and free-run");
      #2;
      check_output();
      do_reset();
      tick_count = 0;
      for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("ticks_in_40", 8'(tick_count), 8'd10);
      check_val("free_run_sec", {sec_tens, sec_ones}, 8'h10);

      $display("[TB] 23:59:58 rollover");
      do_reset();
      for (int i = 0; i < 23; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 59; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 58 * HZ; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("midnight_hr", {hr_tens, hr_ones}, 8'h00);
      check_val("midnight_min", {min_tens, min_ones}, 8'h00);

      $display("[TB] set_min wrap and set_hr sweep");
      for (int i = 0; i < 59; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("set_min_wrap_hr", {hr_tens, hr_ones}, 8'h00);
      for (int i = 0; i < 24; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("set_hr_24_wrap", {hr_tens, hr_ones}, 8'h00);

      $display("[TB] clr_sec at second 59");
      do_reset();
      guard = 0;
      while (!(m_ss == 59 && m_phase == HZ - 1) && guard < 400) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      check_val("reach_59_in_budget", {7'd0, guard < 400}, 8'd1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      check_val("clr_sec_no_tick", {7'd0, tick}, 8'd0);
      check_val("clr_sec_min", {min_tens, min_ones}, 8'h00);

      $display("[TB] hold with run low");
      do_reset();
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 34; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 56 * HZ; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_count = 0;
      for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("hold_ticks", 8'(tick_count), 8'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("hold_set_min", {min_tens, min_ones}, 8'h35);
      check_val("hold_sec", {sec_tens, sec_ones}, 8'h56);

      $display("[TB] async reset at 07:07:07");
      do_reset();
      for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7 * HZ; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("pre_reset_sec", {sec_tens, sec_ones}, 8'h07);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_output();
      #2;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 9) != 0);
         sh = ($urandom_range(0, 19) == 0);
         sm = ($urandom_range(0, 9) == 0);
         cs = ($urandom_range(0, 29) == 0);
         apply_stimulus(r, sh, sm, cs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
      $finish;
   end

endmodule
